fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program-loadable synchronous instruction memory, PC
// sequencing with JR/JALR > J/JAL > branch redirect priority, stall/flush and halt.
module fetch_unit #(
   parameter int                        NB_PC          = 32,
   parameter int                        NB_INSTRUCTION = 32,
   parameter int                        PC_INCREMENT   = 4,
   parameter logic [NB_PC-1:0]          RESET_PC       = '0,
   parameter int                        MEM_DEPTH      = 256,
   parameter logic [NB_INSTRUCTION-1:0] HALT_OPCODE    = '1,
   localparam int                       NB_ADDR        = $clog2(MEM_DEPTH)
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic                      i_stall,
   input  logic                      i_flush,
   input  logic                      i_branch,
   input  logic [NB_PC-1:0]          i_branch_addr,
   input  logic                      i_j_jal,
   input  logic [NB_PC-1:0]          i_jump_addr,
   input  logic                      i_jr_jalr,
   input  logic [NB_PC-1:0]          i_reg_addr,
   input  logic                      i_wr_enable,
   input  logic [NB_ADDR-1:0]        i_wr_addr,
   input  logic [NB_INSTRUCTION-1:0] i_wr_data,
   output logic [NB_PC-1:0]          o_pc,
   output logic [NB_PC-1:0]          o_pc_plus,
   output logic [NB_INSTRUCTION-1:0] o_instruction,
   output logic                      o_valid,
   output logic                      o_halted,
   output logic [1:0]                o_state
);

   localparam int               SHIFT   = $clog2(PC_INCREMENT);
   localparam logic [NB_PC-1:0] PC_STEP = NB_PC'(PC_INCREMENT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t                    state;
   state_t                    state_next;
   logic [NB_PC-1:0]          fetch_pc;
   logic [NB_PC-1:0]          fetch_pc_next;
   logic [NB_PC-1:0]          target;
   logic [NB_ADDR-1:0]        rd_index;
   logic                      redirect;
   logic                      halt_seen;
   logic                      issue;
   logic                      squash;
   logic                      drop_valid;
   logic [NB_INSTRUCTION-1:0] mem [MEM_DEPTH];

   // Byte PC to word index; the upper PC bits are dropped so fetch wraps.
   assign rd_index  = fetch_pc[SHIFT +: NB_ADDR];
   assign redirect  = i_jr_jalr | i_j_jal | i_branch;
   assign target    = i_jr_jalr ? i_reg_addr :
                      i_j_jal   ? i_jump_addr : i_branch_addr;
   assign halt_seen = (state == RUN) && o_valid && (o_instruction == HALT_OPCODE);

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
      end
   end

   // A halt word on the output wins over everything: the word fetched behind
   // it is discarded and the PC freezes.
   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      issue         = 1'b0;
      squash        = 1'b0;
      drop_valid    = 1'b0;
      case (state)
         IDLE: begin
            if (i_enable) begin
               state_next = RUN;
               issue      = ~i_stall;
            end
         end
         RUN: begin
            if (halt_seen) begin
               state_next = HALTED;
               drop_valid = 1'b1;
            end else if (redirect) begin
               squash        = 1'b1;
               fetch_pc_next = target;
            end else if (i_flush) begin
               squash = 1'b1;
               if (i_enable && !i_stall) fetch_pc_next = fetch_pc + PC_STEP;
            end else if (i_enable && !i_stall) begin
               issue = 1'b1;
            end
         end
         HALTED: drop_valid = 1'b1;
         default: state_next = IDLE;
      endcase
      if (issue) fetch_pc_next = fetch_pc + PC_STEP;
   end

   // o_valid marks a real instruction on o_instruction/o_pc; there is no
   // back-pressure, downstream holds the stage with i_stall instead.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_pc          <= RESET_PC;
         o_instruction <= '0;
         o_valid       <= 1'b0;
      end else if (issue) begin
         o_pc          <= fetch_pc;
         o_instruction <= mem[rd_index];
         o_valid       <= 1'b1;
      end else if (squash) begin
         o_pc          <= fetch_pc;
         o_instruction <= '0;
         o_valid       <= 1'b0;
      end else if (drop_valid) begin
         o_valid <= 1'b0;
      end
   end

   // Loading is locked out while running; a same-cycle read sees the old word.
   always_ff @(posedge i_clock) begin
      if (i_wr_enable && (state != RUN)) mem[i_wr_addr] <= i_wr_data;
   end

   assign o_pc_plus = o_pc + PC_STEP;
   assign o_halted  = (state == HALTED) || halt_seen;
   assign o_state   = state;

endmodule
